// File: rtl/fft_pkg.sv
// Shared FFT/IFFT constants, sample/state types and the bit-reverse helper.
package fft_pkg;

  localparam int unsigned BUFFER_SIZE      = 8;
  localparam int unsigned SAMPLE_SIZE      = 16;
  localparam int unsigned TWIDDLE_SIZE     = 16;
  localparam int unsigned LOG2_BUFFER_SIZE = $clog2(BUFFER_SIZE);

  typedef struct packed {
    logic signed [SAMPLE_SIZE-1:0] re;
    logic signed [SAMPLE_SIZE-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN
  } ifft_state_t;

  // Reverses the low `bits` bits of k; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) begin
        r = (r << 1) | ((k >> i) & 32'd1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_iterative_if.sv
// Bin input stream and sample output stream of the iterative IFFT engine.
interface ifft_iterative_if #(
  parameter int unsigned SAMPLE_SIZE = fft_pkg::SAMPLE_SIZE
);

  logic                          in_valid;
  logic                          in_ready;
  logic signed [SAMPLE_SIZE-1:0] in_real;
  logic signed [SAMPLE_SIZE-1:0] in_imag;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [SAMPLE_SIZE-1:0] out_real;
  logic signed [SAMPLE_SIZE-1:0] out_imag;
  logic                          out_last;

  // master: the environment feeding bins and taking samples; slave: the engine.
  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last
  );

endinterface

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 IFFT butterfly: conjugate-twiddle multiply, add/sub, halve, saturate.
// IFFT_ROUND_EN selects round-half-up instead of truncation for the per-stage halving.
module ifft_butterfly #(
  parameter int unsigned SAMPLE_SIZE  = 16,
  parameter int unsigned TWIDDLE_SIZE = 16
) (
  input  logic signed [SAMPLE_SIZE-1:0]  a_re,
  input  logic signed [SAMPLE_SIZE-1:0]  a_im,
  input  logic signed [SAMPLE_SIZE-1:0]  b_re,
  input  logic signed [SAMPLE_SIZE-1:0]  b_im,
  input  logic signed [TWIDDLE_SIZE-1:0] w_re,
  input  logic signed [TWIDDLE_SIZE-1:0] w_im,
  output logic signed [SAMPLE_SIZE-1:0]  a_out_re,
  output logic signed [SAMPLE_SIZE-1:0]  a_out_im,
  output logic signed [SAMPLE_SIZE-1:0]  b_out_re,
  output logic signed [SAMPLE_SIZE-1:0]  b_out_im
);

  localparam int unsigned PW = SAMPLE_SIZE + TWIDDLE_SIZE + 1;
  localparam int unsigned SW = SAMPLE_SIZE + 2;

  localparam logic signed [SW-1:0] SMAX = {3'b000, {(SAMPLE_SIZE - 1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(SAMPLE_SIZE - 1){1'b0}}};

  logic signed [PW-1:0] w_br, w_bi, w_wr, w_wi;
  logic signed [PW-1:0] w_prod_re, w_prod_im;
  logic signed [SW-1:0] w_p_re, w_p_im;
  logic signed [SW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  function automatic logic signed [SAMPLE_SIZE-1:0] scale_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] h;
`ifdef IFFT_ROUND_EN
    h = (v + SW'(1)) >>> 1;
`else
    h = v >>> 1;
`endif
    if (h > SMAX) begin
      h = SMAX;
    end else if (h < SMIN) begin
      h = SMIN;
    end
    return $signed(h[SAMPLE_SIZE-1:0]);
  endfunction

  always_comb begin
    w_br = PW'(b_re);
    w_bi = PW'(b_im);
    w_wr = PW'(w_re);
    w_wi = PW'(w_im);
    // b times conj(w): (wr - j*wi)(br + j*bi)
    w_prod_re = w_wr * w_br + w_wi * w_bi;
    w_prod_im = w_wr * w_bi - w_wi * w_br;
    w_p_re    = SW'(w_prod_re >>> (TWIDDLE_SIZE - 1));
    w_p_im    = SW'(w_prod_im >>> (TWIDDLE_SIZE - 1));
    w_sum_re  = SW'(a_re) + w_p_re;
    w_sum_im  = SW'(a_im) + w_p_im;
    w_dif_re  = SW'(a_re) - w_p_re;
    w_dif_im  = SW'(a_im) - w_p_im;
    a_out_re  = scale_sat(w_sum_re);
    a_out_im  = scale_sat(w_sum_im);
    b_out_re  = scale_sat(w_dif_re);
    b_out_im  = scale_sat(w_dif_im);
  end

endmodule

// File: rtl/ifft_iterative.sv
// Single-buffered in-place radix-2 IFFT: bit-reversed load, one butterfly per cycle, natural drain.
// IFFT_ROUND_EN (in ifft_butterfly) enables round-half-up per-stage scaling.
module ifft_iterative #(
  parameter int unsigned BUFFER_SIZE  = fft_pkg::BUFFER_SIZE,
  parameter int unsigned SAMPLE_SIZE  = fft_pkg::SAMPLE_SIZE,
  parameter int unsigned TWIDDLE_SIZE = fft_pkg::TWIDDLE_SIZE
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [TWIDDLE_SIZE*BUFFER_SIZE/2-1:0]   twiddles_real,
  input  logic [TWIDDLE_SIZE*BUFFER_SIZE/2-1:0]   twiddles_imag,
  output logic                                    busy,
  ifft_iterative_if.slave                         bus
);

  import fft_pkg::*;

  localparam int unsigned LOG2N = $clog2(BUFFER_SIZE);
  localparam int unsigned AW    = LOG2N;
  localparam int unsigned TWB   = TWIDDLE_SIZE * BUFFER_SIZE / 2;

  ifft_state_t r_state;
  logic [AW-1:0] r_cnt, r_stage, r_bfly;
  logic r_out_valid, r_out_last;
  logic signed [SAMPLE_SIZE-1:0] r_out_re, r_out_im;
  logic signed [SAMPLE_SIZE-1:0] r_mem_re [BUFFER_SIZE];
  logic signed [SAMPLE_SIZE-1:0] r_mem_im [BUFFER_SIZE];

  logic w_load_fire;
  logic [31:0] w_rev32, w_t32, w_s32, w_half32, w_j32, w_a32, w_tw32;
  logic [AW-1:0] w_load_addr, w_a_idx, w_b_idx;
  logic [TWB-1:0] w_tw_re_sh, w_tw_im_sh;
  logic signed [TWIDDLE_SIZE-1:0] w_tw_re, w_tw_im;
  logic signed [SAMPLE_SIZE-1:0] w_a_re, w_a_im, w_b_re, w_b_im;

  assign bus.in_ready  = !rst && (r_state == LOAD);
  assign busy          = !rst && (r_state != LOAD);
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_real  = r_out_re;
  assign bus.out_imag  = r_out_im;
  assign w_load_fire   = bus.in_valid && bus.in_ready;

  // Stage r_stage (0-based) has half-span 2^r_stage; butterfly t splits into group and offset j.
  always_comb begin
    w_rev32     = bitrev(32'(r_cnt), LOG2N);
    w_load_addr = w_rev32[AW-1:0];
    w_t32       = 32'(r_bfly);
    w_s32       = 32'(r_stage);
    w_half32    = 32'd1 << w_s32;
    w_j32       = w_t32 & (w_half32 - 32'd1);
    w_a32       = ((w_t32 >> w_s32) << (w_s32 + 32'd1)) | w_j32;
    w_a_idx     = w_a32[AW-1:0];
    w_b_idx     = w_a_idx | w_half32[AW-1:0];
    w_tw32      = w_j32 << (32'(LOG2N) - 32'd1 - w_s32);
    w_tw_re_sh  = twiddles_real >> (w_tw32 * TWIDDLE_SIZE);
    w_tw_im_sh  = twiddles_imag >> (w_tw32 * TWIDDLE_SIZE);
    w_tw_re     = w_tw_re_sh[TWIDDLE_SIZE-1:0];
    w_tw_im     = w_tw_im_sh[TWIDDLE_SIZE-1:0];
  end

  ifft_butterfly #(
    .SAMPLE_SIZE  (SAMPLE_SIZE),
    .TWIDDLE_SIZE (TWIDDLE_SIZE)
  ) u_butterfly (
    .a_re     (r_mem_re[w_a_idx]),
    .a_im     (r_mem_im[w_a_idx]),
    .b_re     (r_mem_re[w_b_idx]),
    .b_im     (r_mem_im[w_b_idx]),
    .w_re     (w_tw_re),
    .w_im     (w_tw_im),
    .a_out_re (w_a_re),
    .a_out_im (w_a_im),
    .b_out_re (w_b_re),
    .b_out_im (w_b_im)
  );

  // Sample storage is never cleared; a full load overwrites every location.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_mem_re[w_load_addr] <= bus.in_real;
      r_mem_im[w_load_addr] <= bus.in_imag;
    end else if (!rst && r_state == COMPUTE) begin
      r_mem_re[w_a_idx] <= w_a_re;
      r_mem_im[w_a_idx] <= w_a_im;
      r_mem_re[w_b_idx] <= w_b_re;
      r_mem_im[w_b_idx] <= w_b_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_bfly      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (w_load_fire) begin
            if (r_cnt == AW'(BUFFER_SIZE - 1)) begin
              r_cnt   <= '0;
              r_stage <= '0;
              r_bfly  <= '0;
              r_state <= COMPUTE;
            end else begin
              r_cnt <= r_cnt + AW'(1);
            end
          end
        end
        COMPUTE: begin
          if (r_bfly == AW'(BUFFER_SIZE / 2 - 1)) begin
            r_bfly <= '0;
            if (r_stage == AW'(LOG2N - 1)) begin
              r_cnt   <= '0;
              r_state <= DRAIN;
            end else begin
              r_stage <= r_stage + AW'(1);
            end
          end else begin
            r_bfly <= r_bfly + AW'(1);
          end
        end
        DRAIN: begin
          // First DRAIN cycle only primes the output register from address 0.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_re    <= r_mem_re[r_cnt];
            r_out_im    <= r_mem_im[r_cnt];
            r_out_last  <= (r_cnt == AW'(BUFFER_SIZE - 1));
          end else if (bus.out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_re    <= '0;
              r_out_im    <= '0;
              r_cnt       <= '0;
              r_state     <= LOAD;
            end else begin
              r_cnt      <= r_cnt + AW'(1);
              r_out_re   <= r_mem_re[r_cnt + AW'(1)];
              r_out_im   <= r_mem_im[r_cnt + AW'(1)];
              r_out_last <= ((r_cnt + AW'(1)) == AW'(BUFFER_SIZE - 1));
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_iterative.sv
// Directed bench for ifft_iterative at N=8 with hand-computed Q1.15 results; honours IFFT_ROUND_EN.
module tb_ifft_iterative;

  localparam int unsigned N  = 8;
  localparam int unsigned SS = 16;
  localparam int unsigned TS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic [TS*N/2-1:0] tw_re, tw_im;

  ifft_iterative_if #(.SAMPLE_SIZE(SS)) u_if ();

  ifft_iterative #(
    .BUFFER_SIZE  (N),
    .SAMPLE_SIZE  (SS),
    .TWIDDLE_SIZE (TS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .twiddles_real (tw_re),
    .twiddles_imag (tw_im),
    .busy          (busy),
    .bus           (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int latency;
  logic signed [SS-1:0] in_re [N];
  logic signed [SS-1:0] in_im [N];
  logic signed [SS-1:0] got_re [N];
  logic signed [SS-1:0] got_im [N];
  logic got_last [N];
  int exp_re [N];
  int exp_im [N];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_in();
    for (int k = 0; k < N; k++) begin
      in_re[k] = '0;
      in_im[k] = '0;
    end
  endtask

  task automatic send_frame(input int gap_at);
    int guard;
    for (int k = 0; k < N; k++) begin
      if (k == gap_at) begin
        u_if.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
      u_if.in_valid = 1'b1;
      u_if.in_real  = in_re[k];
      u_if.in_imag  = in_im[k];
      guard = 0;
      while (u_if.in_ready !== 1'b1 && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) begin
        n_cmp++;
        n_bad++;
        $error("FAIL in_ready_timeout: observed beat %0d stuck expected ready", k);
      end
      @(posedge clk); #1;
    end
    u_if.in_valid = 1'b0;
  endtask

  task automatic recv_frame(input int stall_beat);
    int beat = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic signed [SS-1:0] hold_re, hold_im;
    u_if.out_ready = 1'b1;
    while (beat < N && guard < 200) begin
      if (u_if.out_valid === 1'b1) begin
        if (beat == stall_beat && !stalled) begin
          u_if.out_ready = 1'b0;
          hold_re = u_if.out_real;
          hold_im = u_if.out_imag;
          for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("stall_valid", u_if.out_valid, 1);
            check("stall_real", u_if.out_real, hold_re);
            check("stall_imag", u_if.out_imag, hold_im);
          end
          u_if.out_ready = 1'b1;
          stalled = 1'b1;
        end
        got_re[beat]   = u_if.out_real;
        got_im[beat]   = u_if.out_imag;
        got_last[beat] = u_if.out_last;
        beat++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (beat < N) begin
      n_cmp++;
      n_bad++;
      $error("FAIL recv_timeout: observed %0d beats expected %0d", beat, N);
    end
  endtask

  task automatic compare_frame(input string tag);
    for (int n = 0; n < N; n++) begin
      check($sformatf("%s_re[%0d]", tag, n), got_re[n], exp_re[n]);
      check($sformatf("%s_im[%0d]", tag, n), got_im[n], exp_im[n]);
      check($sformatf("%s_last[%0d]", tag, n), got_last[n], (n == N - 1) ? 1 : 0);
    end
  endtask

  task automatic set_exp_const(input int re_v);
    for (int n = 0; n < N; n++) begin
      exp_re[n] = re_v;
      exp_im[n] = 0;
    end
  endtask

  task automatic set_exp_rot();
`ifdef IFFT_ROUND_EN
    exp_re = '{1000, 707, 0, -707, -999, -707, 0, 708};
    exp_im = '{0, 707, 1000, 707, 0, -707, -999, -707};
`else
    exp_re = '{999, 707, 0, -708, -1000, -707, 0, 707};
    exp_im = '{0, 707, 999, 707, 0, -707, -1000, -707};
`endif
  endtask

  initial begin
    // Q1.15 forward twiddles W8^k, slot k at bits [16k +: 16].
    tw_re = {16'hA57E, 16'h0000, 16'h5A82, 16'h7FFF};
    tw_im = {16'hA57E, 16'h8001, 16'hA57E, 16'h0000};
    u_if.in_valid  = 1'b0;
    u_if.in_real   = '0;
    u_if.in_imag   = '0;
    u_if.out_ready = 1'b0;

    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_in_ready", u_if.in_ready, 0);
    check("rst_out_valid", u_if.out_valid, 0);
    check("rst_out_real", u_if.out_real, 0);
    check("rst_out_imag", u_if.out_imag, 0);
    check("rst_out_last", u_if.out_last, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", u_if.in_ready, 1);

    // DC impulse
    clear_in();
    in_re[0] = 16'sd8000;
    send_frame(-1);
    check("dc_in_ready_low", u_if.in_ready, 0);
    check("dc_busy", busy, 1);
    recv_frame(-1);
    set_exp_const(1000);
    compare_frame("dc");
    check("dc_ready_after", u_if.in_ready, 1);
    check("dc_busy_after", busy, 0);

    // Bin 1 impulse, throttled input
    clear_in();
    in_re[1] = 16'sd8000;
    send_frame(3);
    recv_frame(-1);
    set_exp_rot();
    compare_frame("rot");

    // All-zero frame and compute latency
    clear_in();
    send_frame(-1);
    latency = 0;
    while (u_if.out_valid !== 1'b1 && latency < 100) begin
      @(posedge clk); #1;
      latency++;
    end
    check("latency", latency, 13);
    recv_frame(-1);
    set_exp_const(0);
    compare_frame("zero");

    // Small DC: scaling precision
    clear_in();
    in_re[0] = 16'sd4;
    send_frame(-1);
    recv_frame(-1);
`ifdef IFFT_ROUND_EN
    set_exp_const(1);
`else
    set_exp_const(0);
`endif
    compare_frame("small");

    // Backpressure at beat 4
    clear_in();
    in_re[1] = 16'sd8000;
    send_frame(-1);
    recv_frame(4);
    set_exp_rot();
    compare_frame("stall");

    // Reset mid-COMPUTE, then a fresh frame
    clear_in();
    in_re[1] = 16'sd8000;
    send_frame(-1);
    repeat (4) begin @(posedge clk); #1; end
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", u_if.in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", u_if.out_valid, 0);
    check("mid_rst_out_real", u_if.out_real, 0);
    check("mid_rst_out_imag", u_if.out_imag, 0);
    check("mid_rst_out_last", u_if.out_last, 0);
    @(posedge clk); #1;
    check("mid_rst_edge_busy", busy, 0);
    check("mid_rst_edge_out_valid", u_if.out_valid, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_release_ready", u_if.in_ready, 1);
    clear_in();
    in_re[0] = 16'sd8000;
    send_frame(-1);
    recv_frame(-1);
    set_exp_const(1000);
    compare_frame("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
